mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Multicycle control unit for the MIPS core. A Moore state machine sequences one shared ALU, one unified instruction/data memory and the 32x32 register file over several cycles per instruction. It produces every datapath select and write enable, including the register-file write enable and destination select. It sits beside the datapath and sees only the instruction opcode/funct fields and the ALU zero flag.

## Interface
Parameters:
- none; opcode and funct encodings are fixed by the MIPS ISA.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU result == 0
- pc_en  out  1  PC load enable = pc_write | (branch & zero)
- iord  out  1  memory address: 0 = PC, 1 = ALU out register
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register load
- reg_dst  out  1  register-file write address: 0 = rt, 1 = rd
- mem_to_reg  out  1  register-file write data: 0 = ALU out, 1 = memory data register
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  out  2  00 = ALU result, 01 = ALU out register, 10 = jump target
- retire  out  1  high in the last cycle of each instruction
- state  out  4  current state, for debug

## Operation
State encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Encodings 12–15 are unreachable; if ever entered, next state is FETCH and all outputs are 0.

Transitions:
- FETCH→DECODE.
- DECODE branches on opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → RTEX
  - 000100 (beq) → BEQEX
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JEX
  - any other opcode → FETCH; the instruction acts as a nop and retire is high in DECODE.
- MEMADR → MEMRD if opcode is lw, else MEMWR.
- MEMRD→MEMWB; RTEX→RTWB; ADDIEX→ADDIWB.
- MEMWB, MEMWR, RTWB, BEQEX, ADDIWB, JEX → FETCH.

Outputs per state (anything not listed is 0; alu_control defaults to 010):
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00, ir_write=1, pc_write=1.
- DECODE: alu_src_a=0, alu_src_b=11, add (precomputes the branch target).
- MEMADR: alu_src_a=1, alu_src_b=10, add.
- MEMRD: iord=1.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
- MEMWR: iord=1, mem_write=1.
- RTEX: alu_src_a=1, alu_src_b=00; alu_control from funct:
  - 100000→010, 100010→110, 100100→000, 100101→001, 101010→111
  - any other funct → 010
- RTWB: reg_dst=1, mem_to_reg=0, reg_write=1.
- BEQEX: alu_src_a=1, alu_src_b=00, sub, pc_src=01, branch=1.
- ADDIEX: alu_src_a=1, alu_src_b=10, add.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
- JEX: pc_src=10, pc_write=1.

Combinational outputs:
- All outputs are combinational from state, plus opcode/funct/zero where noted above.
- pc_en combines zero in the same cycle.
- retire is high in MEMWB, MEMWR, RTWB, BEQEX, ADDIWB, JEX, and in DECODE for an unsupported opcode.

## Timing
Reset:
- reset sampled high at a rising edge → state=FETCH after that edge.
- While reset is high, pc_en, ir_write, mem_write, reg_write and retire are forced to 0; the other outputs follow state.
- First FETCH with writes enabled is the first cycle with reset low.
- Reset asserted mid-instruction aborts it at the next edge. No write enable is asserted during the reset cycle, so the register file and memory are never partially updated.

Cycles per instruction (FETCH through the retire cycle inclusive):
- lw 5
- sw, R-type, addi 4
- beq, j 3
- unsupported opcode 2

Input stability:
- opcode and funct are stable from DECODE onward, because ir_write is asserted only in FETCH.
- zero is sampled only in BEQEX.
- beq not taken (zero=0): pc_en=0, and the PC keeps PC+4 written in FETCH.

## Test plan
- Reset: hold reset 2 cycles with opcode=100011 → state=0; pc_en, ir_write, reg_write, mem_write all 0 during reset. First cycle after release shows ir_write=1, pc_en=1.
- lw: opcode 100011 → states 0,1,2,3,4. In state 4: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1. Back to 0 in cycle 6.
- sw/addi: opcode 101011 → states 0,1,2,5 with mem_write=1 only in state 5. Opcode 001000 → states 0,1,9,10 with reg_write=1, reg_dst=0 in state 10.
- R-type ALU decode: funct 100010 → alu_control=110 in RTEX. Repeat for 100000, 100100, 100101, 101010 and 000000 (expect 010). RTWB: reg_write=1, reg_dst=1.
- beq/j: opcode 000100 with zero=1 → pc_en=1, pc_src=01 in BEQEX; with zero=0 → pc_en=0. Opcode 000010 → JEX pc_en=1, pc_src=10. Both retire in cycle 3.
- Unsupported opcode and abort: opcode 111111 → 0,1,0 with retire=1 in DECODE and no write enable. Reset asserted in MEMRD → state 0 next cycle, reg_write never asserted.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Brief    : Moore-style multicycle MIPS control unit sequencing the shared
//            ALU, unified memory and register file.
// Revision : 1.0 - initial release
// ============================================================================

module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       retire,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_iord;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [2:0] w_alu_control;
    logic [1:0] w_pc_src;
    logic       w_retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = S_FETCH;
        w_pc_write    = 1'b0;
        w_branch      = 1'b0;
        w_iord        = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_reg_dst     = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_reg_write   = 1'b0;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = 2'b00;
        w_alu_control = c_ALU_ADD;
        w_pc_src      = 2'b00;
        w_retire      = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_next      = S_DECODE;
                w_alu_src_b = 2'b01;
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode resolves.
                w_alu_src_b = 2'b11;
                case (opcode)
                    c_OP_LW,
                    c_OP_SW:     w_next = S_MEMADR;
                    c_OP_RTYPE:  w_next = S_RTEX;
                    c_OP_BEQ:    w_next = S_BEQEX;
                    c_OP_ADDI:   w_next = S_ADDIEX;
                    c_OP_J:      w_next = S_JEX;
                    default: begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_next      = (opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                w_next = S_MEMWB;
                w_iord = 1'b1;
            end
            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
            end
            S_MEMWR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_RTEX: begin
                w_next      = S_RTWB;
                w_alu_src_a = 1'b1;
                case (funct)
                    6'b100000: w_alu_control = c_ALU_ADD;
                    6'b100010: w_alu_control = c_ALU_SUB;
                    6'b100100: w_alu_control = c_ALU_AND;
                    6'b100101: w_alu_control = c_ALU_OR;
                    6'b101010: w_alu_control = c_ALU_SLT;
                    default:   w_alu_control = c_ALU_ADD;
                endcase
            end
            S_RTWB: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_BEQEX: begin
                w_alu_src_a   = 1'b1;
                w_alu_control = c_ALU_SUB;
                w_pc_src      = 2'b01;
                w_branch      = 1'b1;
                w_retire      = 1'b1;
            end
            S_ADDIEX: begin
                w_next      = S_ADDIWB;
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_JEX: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
            end
            default: begin
                // Encodings 12-15: recover to FETCH with every output low.
                w_next        = S_FETCH;
                w_alu_control = 3'b000;
            end
        endcase
    end

    // Write enables are masked during reset so an aborted instruction leaves no partial update.
    assign pc_en       = ~reset & (w_pc_write | (w_branch & zero));
    assign ir_write    = ~reset & w_ir_write;
    assign mem_write   = ~reset & w_mem_write;
    assign reg_write   = ~reset & w_reg_write;
    assign retire      = ~reset & w_retire;
    assign iord        = w_iord;
    assign reg_dst     = w_reg_dst;
    assign mem_to_reg  = w_mem_to_reg;
    assign alu_src_a   = w_alu_src_a;
    assign alu_src_b   = w_alu_src_b;
    assign alu_control = w_alu_control;
    assign pc_src      = w_pc_src;
    assign state       = r_state;

endmodule

`default_nettype wire
